// File: rtl/keypad_pkg.sv
// Keypad encoder shared definitions: code points, FSM states, key mapping.
// No ports; imported by keypad_scan_encoder.
package keypad_pkg;

  localparam logic [3:0] CODE_IDLE   = 4'b1111;
  localparam logic [3:0] CODE_SET    = 4'b1110;
  localparam logic [3:0] CODE_CANCEL = 4'b1101;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Rows 0..2 hold digits 1..9; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_to_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] c;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    c = CODE_CANCEL;
        2'd1:    c = 4'b0000;
        default: c = CODE_SET;
      endcase
    end else begin
      c = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// 2-flop synchronizer for the asynchronous keypad rows (idle = all ones).
// Ports: clk, rst_n (async low), d[3:0] raw rows, q[3:0] synchronized rows.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// Scans a 4x3 active-low keypad, debounces it and emits one code per press.
// Ports: clk, rst_n, ena, row_n[3:0] in; col_n[2:0], code[3:0], key_valid, key_down out.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [3:0] row_s;

  keypad_row_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]  cand_q, cand_d;
  logic [2:0]  col_n_q, col_n_d;
  logic [3:0]  code_q, code_d;
  logic        kv_q, kv_d;
  logic        kd_q, kd_d;

  logic        last;
  logic        frame_end;
  logic [11:0] sample;
  int          nkeys;
  logic [3:0]  fcode;
  logic        go_emit;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] rcnt_inc;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    hold_d   = hold_q;
    cand_d   = cand_q;
    col_n_d  = col_n_q;
    code_d   = code_q;
    kv_d     = 1'b0;
    kd_d     = kd_q;
    go_emit  = 1'b0;
    fcode    = CODE_IDLE;
    cnt_inc  = cnt_q + CW'(1);
    rcnt_inc = rcnt_q + CW'(1);

    last      = (div_q == DW'(SCAN_DIV - 1));
    frame_end = last && (idx_q == 2'd2);

    // Current frame including this cycle's column sample.
    sample = snap_q;
    if (last) begin
      for (int r = 0; r < 4; r++) begin
        sample[4'(r * 3) + {2'b00, idx_q}] = ~row_s[r];
      end
    end
    nkeys = $countones(sample);
    for (int i = 0; i < 12; i++) begin
      if (sample[i]) fcode = key_to_code(2'(i / 3), 2'(i % 3));
    end

    if (!ena) begin
      state_d = SCAN;
      div_d   = '0;
      idx_d   = '0;
      snap_d  = '0;
      cnt_d   = '0;
      rcnt_d  = '0;
      hold_d  = '0;
      col_n_d = 3'b111;
      code_d  = CODE_IDLE;
      kd_d    = 1'b0;
    end else begin
      div_d   = last ? '0 : div_q + DW'(1);
      idx_d   = !last ? idx_q :
                (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      col_n_d = ~(3'b001 << idx_d);
      snap_d  = frame_end ? '0 : sample;

      unique case (state_q)
        SCAN: begin
          if (frame_end && nkeys == 1) begin
            cand_d = fcode;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) go_emit = 1'b1;
            else state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (frame_end) begin
            if (nkeys == 1 && fcode == cand_q) begin
              if (cnt_inc == CW'(DEBOUNCE_SCANS)) go_emit = 1'b1;
              else cnt_d = cnt_inc;
            end else begin
              state_d = SCAN;
              cnt_d   = '0;
            end
          end
        end
        EMIT: begin
          if (hold_q >= HW'(HOLD_CYCLES)) begin
            code_d  = CODE_IDLE;
            state_d = RELEASE;
            rcnt_d  = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RELEASE: begin
          if (frame_end) begin
            if (nkeys == 0) begin
              if (rcnt_inc == CW'(DEBOUNCE_SCANS)) begin
                state_d = SCAN;
                kd_d    = 1'b0;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_inc;
              end
            end else begin
              rcnt_d = '0;
            end
          end
        end
        default: state_d = SCAN;
      endcase

      // Code is presented from the edge that enters EMIT.
      if (go_emit) begin
        state_d = EMIT;
        code_d  = cand_d;
        kv_d    = 1'b1;
        kd_d    = 1'b1;
        hold_d  = HW'(1);
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      div_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      hold_q  <= '0;
      cand_q  <= CODE_IDLE;
      col_n_q <= 3'b111;
      code_q  <= CODE_IDLE;
      kv_q    <= 1'b0;
      kd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      hold_q  <= hold_d;
      cand_q  <= cand_d;
      col_n_q <= col_n_d;
      code_q  <= code_d;
      kv_q    <= kv_d;
      kd_q    <= kd_d;
    end
  end

  assign col_n     = col_n_q;
  assign code      = code_q;
  assign key_valid = kv_q;
  assign key_down  = kd_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Randomized frame-level bench for keypad_scan_encoder.
// Drives a modelled 4x3 keypad and checks codes against an event model.
module tb_keypad_scan_encoder;

  localparam int SD = 4;
  localparam int DS = 2;
  localparam int HC = 1;

  localparam int K1 = 0, K2 = 1, K3 = 2, K5 = 4, K7 = 6, K9 = 8;
  localparam int KSTAR = 9, K0 = 10, KHASH = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] code;
  logic       key_valid;
  logic       key_down;
  logic [11:0] keys = '0;

  int checks = 0;
  int errors = 0;

  logic [3:0] kcode [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                             4'd7, 4'd8, 4'd9, 4'b1101, 4'd0, 4'b1110};

  keypad_scan_encoder #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .row_n     (row_n),
    .col_n     (col_n),
    .code      (code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] kb(input int i);
    logic [11:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Event model: press accepted after DS identical single-key frames,
  // re-armed after DS empty frames.
  int   m_run, m_key, m_zrun;
  bit   m_down;
  bit   p_emit, p_down;
  logic [3:0] p_code;

  task automatic model_reset();
    m_run = 0; m_key = 0; m_zrun = 0; m_down = 0;
    p_emit = 0; p_down = 0; p_code = 4'hF;
  endtask

  task automatic model_frame(input logic [11:0] f);
    int n;
    int k;
    n = $countones(f);
    k = 0;
    for (int i = 0; i < 12; i++) if (f[i]) k = i;
    p_emit = 0;
    if (!m_down) begin
      if (m_run > 0) begin
        if (n == 1 && k == m_key) m_run++;
        else m_run = 0;
      end else if (n == 1) begin
        m_run = 1;
        m_key = k;
      end
      if (m_run == DS) begin
        p_emit = 1;
        p_code = kcode[m_key];
        m_down = 1;
        m_run  = 0;
        m_zrun = 0;
      end
    end else begin
      if (n == 0) m_zrun++;
      else m_zrun = 0;
      if (m_zrun == DS) begin
        m_down = 0;
        m_zrun = 0;
      end
    end
    p_down = m_down;
  endtask

  // Leaves the caller at the first negedge of a new frame.
  task automatic sync_frame();
    int n;
    n = 0;
    while (col_n != 3'b011 && n < 40) begin @(negedge clk); n++; end
    while (col_n == 3'b011 && n < 40) begin @(negedge clk); n++; end
    chk("frame_sync", 32'(n < 40), 32'd1);
  endtask

  // Applies one frame of keys and checks the result of the previous frame.
  task automatic run_frame(input logic [11:0] f);
    int pulses, nonidle;
    logic [3:0] cap;
    logic kd;
    logic [2:0] ec;
    pulses = 0; nonidle = 0; cap = 4'hF; kd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) keys = f;
      ec = 3'b111;
      ec[i/SD] = 1'b0;
      chk("col_n", 32'(col_n), 32'(ec));
      if (key_valid) begin pulses++; cap = code; end
      if (code != 4'hF) nonidle++;
      if (i == 5) kd = key_down;
      @(negedge clk);
    end
    chk("kv_pulses", pulses, 32'(p_emit));
    if (p_emit) chk("code", 32'(cap), 32'(p_code));
    chk("nonidle", nonidle, p_emit ? HC : 0);
    chk("key_down", 32'(kd), 32'(p_down));
    model_frame(f);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_col"}, 32'(col_n), 32'h7);
    chk({tag, "_code"}, 32'(code), 32'hF);
    chk({tag, "_kv"}, 32'(key_valid), 32'd0);
    chk({tag, "_kd"}, 32'(key_down), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [11:0] prev, f;
    int r;
    int found;

    model_reset();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("disabled");
    ena = 1'b1;
    sync_frame();

    // Idle, '5', bounced '#', two keys then '*'.
    repeat (2) run_frame('0);
    repeat (3) run_frame(kb(K5));
    repeat (3) run_frame('0);
    run_frame(kb(KHASH));
    repeat (2) run_frame('0);
    repeat (4) run_frame(kb(K1) | kb(K3));
    repeat (2) run_frame('0);
    repeat (3) run_frame(kb(KSTAR));
    repeat (3) run_frame('0);
    // Long hold, second key while held, then '0'.
    repeat (10) run_frame(kb(K9));
    repeat (2) run_frame(kb(K9) | kb(K0));
    repeat (2) run_frame('0);
    repeat (3) run_frame(kb(K0));
    repeat (3) run_frame('0);

    prev = '0;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) f = prev;
      else if (r < 6) f = '0;
      else if (r < 9) f = kb($urandom_range(0, 11));
      else f = kb($urandom_range(0, 11)) | kb($urandom_range(0, 11));
      run_frame(f);
      prev = f;
    end
    repeat (3) run_frame('0);

    // Drop ena while debouncing '7'.
    run_frame(kb(K7));
    repeat (5) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk_idle("ena_drop");
    keys = '0;
    model_reset();
    @(negedge clk);
    ena = 1'b1;
    sync_frame();
    run_frame(kb(K7));
    run_frame(kb(K7));
    repeat (3) run_frame('0);

    // Async reset while the code is on the output.
    keys = kb(K2);
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      if (key_valid) begin
        found = 1;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_emit");
      end else begin
        @(negedge clk);
      end
    end
    chk("emit_seen", 32'(found), 32'd1);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sync_frame();
    run_frame(kb(K2));
    run_frame(kb(K2));
    repeat (3) run_frame('0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
